tx_snapshot_capture: RTL
========================

// Module: tx_snapshot_capture
// PURPOSE
// - Captures a burst of tx_core's parallel DAC sample words into on-chip RAM.
// - Capture starts on an immediate or threshold trigger. The block then streams
//   the burst out on an AXI-Stream master for host-side debug of each tx_core
//   output_select tap.
// - Sits directly downstream of tx_core: taps the dac_data bus in parallel with
//   the RF-DAC; never back-pressures it.
// PARAMETERS
// - NUMBER_OF_LINE  8     samples per clock word (16 bit each, lane 0 in bits [15:0])
// - DEPTH           1024  RAM depth in words; power of two, >= 16
// - ADDR_W          $clog2(DEPTH), derived, not overridable
// PORTS
// - clock           in   1                  sample clock, same domain as tx_core
// - reset           in   1                  synchronous, active-high
// - data_in         in   16*NUMBER_OF_LINE  tx_core dac_data word, valid every cycle
// - arm             in   1                  one-cycle pulse: start a capture
// - trigger_mode    in   1                  0 = immediate, 1 = threshold
// - trigger_level   in   16                 signed threshold
// - capture_len     in   ADDR_W+1           words to capture; 0 or >DEPTH means DEPTH
// - busy            out  1                  high in ARMED/CAPTURE/READOUT
// - triggered       out  1                  sticky, set on trigger, cleared on arm
// - m_axis_tdata    out  16*NUMBER_OF_LINE  captured word
// - m_axis_tvalid   out  1
// - m_axis_tready   in   1
// - m_axis_tlast    out  1                  high on final word of burst
// BEHAVIOUR
// - Reset: state=IDLE, busy=0, triggered=0, tvalid=0, tlast=0, tdata=0, counters=0.
// - data_in registered once (d1); all trigger compare and RAM writes use d1.
// - FSM IDLE -> (arm) ARMED -> (trig) CAPTURE -> (len words written) READOUT -> (tlast accepted) IDLE.
// - arm in IDLE: latch len (0 or >DEPTH -> DEPTH), clear triggered, go ARMED next cycle.
// - arm while busy is ignored; no restart, no abort.
// - Immediate trigger: fires in the first ARMED cycle.
// - Threshold trigger: any lane of d1, signed, strictly > trigger_level.
// - The triggering word itself is RAM word 0.
// - CAPTURE: one word per clock, addresses 0..len-1 consecutive, no gaps.
//   triggered=1 from the trigger cycle.
// - READOUT: RAM read latency 1; one-word skid/prefetch keeps full throughput
//   (one word/cycle at tready=1).
// - While tvalid=1 and tready=0, tdata/tlast stay stable and tvalid stays high.
// - Words emitted in address order 0..len-1; tlast only with word len-1.
// - IDLE entered the cycle after the tlast handshake.
// - Write counter never wraps: len=DEPTH writes 0..DEPTH-1, then stops.
// - reset mid-operation: immediate return to IDLE, tvalid=0 next edge.
//   RAM contents undefined afterwards.
// - Trigger while IDLE/READOUT: ignored. trigger_level/mode sampled live during ARMED.
// CONFIGURATION
// - TX_SNAPSHOT_DECIMATE_EN defined: adds port decimation (in, 8 bits).
//   - Latched on arm.
//   - CAPTURE writes every (decimation+1)th d1 word, the triggering word first.
//   - Capture duration = len*(decimation+1) cycles.
// - Undefined: port absent, every word written (decimation = 0).
// TESTING
// - mode=0, len=4, ramp data_in, tready=1 -> four ramp words 0..3 cycles after
//   trigger, tlast on 4th, busy falls after it.
// - mode=1, level=1000, lane 5 steps to 1001 at cycle 50 -> word 0 is the step
//   word, triggered=1.
// - mode=1, level=1000, lane at exactly 1000, then -2000 -> no trigger, busy=1,
//   tvalid=0 indefinitely.
// - len=0 -> DEPTH words, tlast on word DEPTH-1.
// - tready toggling randomly -> words match RAM order with no duplicates;
//   tdata stable while stalled.
// - Reset asserted mid-READOUT, then arm -> tvalid=0 after reset, fresh capture
//   correct; arm while busy ignored.

Source files
------------

// File: rtl/tx_snapshot_capture.sv
// Trigger-started burst capture of tx_core DAC words into RAM, replayed on an AXI-Stream master.
// Optional TX_SNAPSHOT_DECIMATE_EN adds a decimation port (store every (decimation+1)th word).
module tx_snapshot_capture #(
    parameter int unsigned NUMBER_OF_LINE = 8,
    parameter int unsigned DEPTH          = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [16*NUMBER_OF_LINE-1:0]  data_in,
    input  logic                          arm,
    input  logic                          trigger_mode,
    input  logic [15:0]                   trigger_level,
    input  logic [$clog2(DEPTH):0]        capture_len,
`ifdef TX_SNAPSHOT_DECIMATE_EN
    input  logic [7:0]                    decimation,
`endif
    output logic                          busy,
    output logic                          triggered,
    output logic [16*NUMBER_OF_LINE-1:0]  m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LenW   = ADDR_W + 1;
    localparam int unsigned W      = 16 * NUMBER_OF_LINE;

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StReadout} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      d1_q;
    logic [LenW-1:0]   len_q, len_d;
    logic [LenW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LenW-1:0]   rd_ptr_q, rd_ptr_d;
    logic              triggered_q, triggered_d;
    logic [7:0]        dec_q, dec_d;
    logic [7:0]        skip_q, skip_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [W-1:0]      tdata_q;
    logic [7:0]        dec_in;
    logic [LenW-1:0]   eff_len;
    logic              hit;
    logic              trig;
    logic              we;
    logic              rd_en;
    logic [W-1:0]      mem [DEPTH];

`ifdef TX_SNAPSHOT_DECIMATE_EN
    assign dec_in = decimation;
`else
    assign dec_in = 8'd0;
`endif

    assign eff_len = (capture_len == '0 || capture_len > LenW'(DEPTH)) ? LenW'(DEPTH)
                                                                      : capture_len;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(NUMBER_OF_LINE); i++) begin
            if ($signed(d1_q[16*i +: 16]) > $signed(trigger_level)) begin
                hit = 1'b1;
            end
        end
    end

    assign trig = !trigger_mode || hit;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        triggered_d = triggered_q;
        dec_d       = dec_q;
        skip_d      = skip_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        we          = 1'b0;
        rd_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d     = StArmed;
                    triggered_d = 1'b0;
                    len_d       = eff_len;
                    wr_cnt_d    = '0;
                    rd_ptr_d    = '0;
                    dec_d       = dec_in;
                end
            end
            StArmed: begin
                // The triggering word is stored immediately as word 0.
                if (trig) begin
                    we          = 1'b1;
                    wr_cnt_d    = LenW'(1);
                    triggered_d = 1'b1;
                    skip_d      = dec_q;
                    state_d     = (len_q == LenW'(1)) ? StReadout : StCapture;
                end
            end
            StCapture: begin
                if (skip_q == 8'd0) begin
                    we       = 1'b1;
                    wr_cnt_d = wr_cnt_q + LenW'(1);
                    skip_d   = dec_q;
                    if (wr_cnt_q == len_q - LenW'(1)) begin
                        state_d = StReadout;
                    end
                end else begin
                    skip_d = skip_q - 8'd1;
                end
            end
            StReadout: begin
                // The output register doubles as the RAM read register, refilled on every accept.
                if (!tvalid_q || m_axis_tready) begin
                    if (rd_ptr_q != len_q) begin
                        rd_en    = 1'b1;
                        rd_ptr_d = rd_ptr_q + LenW'(1);
                        tvalid_d = 1'b1;
                        tlast_d  = (rd_ptr_q == len_q - LenW'(1));
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
                if (tvalid_q && m_axis_tready && tlast_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            d1_q        <= '0;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            triggered_q <= 1'b0;
            dec_q       <= '0;
            skip_q      <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            d1_q        <= data_in;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            triggered_q <= triggered_d;
            dec_q       <= dec_d;
            skip_q      <= skip_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            if (rd_en) begin
                tdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (we && !reset) begin
            mem[wr_cnt_q[ADDR_W-1:0]] <= d1_q;
        end
    end

    assign busy          = (state_q != StIdle);
    assign triggered     = triggered_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule
